// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: instruction formats and
// the occupancy states of the two-entry output buffer.
package imm_pkg;

    localparam int IMM_WIDTH = 3;

    typedef enum logic [IMM_WIDTH-1:0] {
        Imm      = 3'd0,
        UpperImm = 3'd1,
        Store    = 3'd2,
        Branch   = 3'd3,
        Jump     = 3'd4,
        Shamt    = 3'd5,
        Csr      = 3'd6
    } instr_format_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: selects and extends the immediate field
// of a RISC-V style instruction word and flags unknown format selects.
module imm_decode #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = imm_pkg::IMM_WIDTH
) (
    input  logic [31:0]           instr,
    input  logic [IMM_WIDTH-1:0]  ImmSrc,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  illegal
);
    import imm_pkg::*;

    logic [31:0] w_i_imm;
    logic [31:0] w_u_imm;
    logic [31:0] w_s_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_j_imm;

    // Formats 0-4 are first built as sign-filled 32-bit values, then widened.
    assign w_i_imm = {{20{instr[31]}}, instr[31:20]};
    assign w_u_imm = {instr[31:12], 12'b0};
    assign w_s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (ImmSrc)
            IMM_WIDTH'(Imm):      imm = DATA_WIDTH'($signed(w_i_imm));
            IMM_WIDTH'(UpperImm): imm = DATA_WIDTH'($signed(w_u_imm));
            IMM_WIDTH'(Store):    imm = DATA_WIDTH'($signed(w_s_imm));
            IMM_WIDTH'(Branch):   imm = DATA_WIDTH'($signed(w_b_imm));
            IMM_WIDTH'(Jump):     imm = DATA_WIDTH'($signed(w_j_imm));
            IMM_WIDTH'(Shamt): begin
                imm[4:0] = instr[24:20];
                if (DATA_WIDTH == 64) imm[5] = instr[25];
            end
            IMM_WIDTH'(Csr):      imm[4:0] = instr[19:15];
            default: begin
                imm     = DATA_WIDTH'($signed(w_i_imm));
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a valid/ready pipeline stage: one output register
// plus one skid register, so in_ready can be registered without losing beats.
module imm_gen_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMM_WIDTH     = imm_pkg::IMM_WIDTH,
    parameter int TAG_WIDTH     = 5,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [IMM_WIDTH-1:0]     ImmSrc,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [1:0]               dbg_state
);
    import imm_pkg::*;

    // A beat on either port transfers on a rising edge where valid and ready
    // are both 1; a presented beat is held unchanged until it transfers.
    localparam int BEAT_W = DATA_WIDTH + TAG_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    w_dec_imm;
    logic                     w_dec_illegal;
    logic [BEAT_W-1:0]        w_in_beat;
    logic                     w_accept;
    logic                     w_drain;
    logic                     w_load_out_in;
    logic                     w_load_out_skid;
    logic                     w_load_skid;
    occ_state_e               w_next_state;

    occ_state_e               r_state;
    logic [BEAT_W-1:0]        r_out_beat;
    logic [BEAT_W-1:0]        r_skid_beat;
    logic                     r_in_ready;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    imm_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_decode (
        .instr   (instr),
        .ImmSrc  (ImmSrc),
        .imm     (w_dec_imm),
        .illegal (w_dec_illegal)
    );

    assign w_in_beat = {w_dec_illegal, in_tag, w_dec_imm};
    assign w_accept  = in_valid && r_in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_next_state    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state  = ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = FULL;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_next_state = EMPTY;
                end
            end
            FULL: begin
                if (w_drain) begin
                    w_next_state    = ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_beat  <= '0;
            r_skid_beat <= '0;
            r_in_ready  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_out_in) begin
                r_out_beat <= w_in_beat;
            end else if (w_load_out_skid) begin
                r_out_beat <= r_skid_beat;
            end
            if (w_load_skid) r_skid_beat <= w_in_beat;
            // Ready looks ahead at the next occupancy so it stays a plain flop.
            r_in_ready <= (w_next_state != FULL);
            if (w_accept && w_dec_illegal && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign ImmOp     = r_out_beat[DATA_WIDTH-1:0];
    assign out_tag   = r_out_beat[DATA_WIDTH +: TAG_WIDTH];
    assign out_err   = r_out_beat[BEAT_W-1];
    assign err_count = r_err_count;
    assign dbg_state = r_state;

endmodule
